ssd1306_spi_receiver: RTL
=========================

// Module: ssd1306_spi_receiver
//
// PURPOSE
//   SSD1306-compatible OLED slave: receives the AVR core's 3-wire OLED output
//   (spi_scl, spi_mosi, DC), decodes the command/data byte stream, and emits
//   framebuffer byte writes for the video scanout. Sits beside atmega32u4 in
//   the clk_avr_16 domain; no chip select exists, so framing runs from reset.
//
// PARAMETERS
//   SYNC_STAGES     2      flops per input synchronizer (>=2)
//   RESET_CONTRAST  8'h7F  contrast register value after reset
//
// PORTS
//   clk          in   1   system clock (clk_avr_16)
//   rst          in   1   synchronous reset, active-high
//   spi_scl      in   1   SPI clock from core, asynchronous to clk
//   spi_mosi     in   1   SPI data, MSB first
//   dc           in   1   0 = command byte, 1 = data byte
//   fb_wr_en     out  1   one-cycle framebuffer write strobe
//   fb_addr      out  10  {page[2:0], col[6:0]}
//   fb_data      out  8   8 vertical pixels, bit0 = top row
//   display_on   out  1   0xAF sets, 0xAE clears
//   invert       out  1   0xA7 sets, 0xA6 clears
//   contrast     out  8   last 0x81 argument
//   frame_done   out  1   only with SSD1306_FRAME_DONE_EN (see CONFIGURATION)
//
// BEHAVIOUR
// - spi_scl, spi_mosi, dc each pass SYNC_STAGES flops; scl rise = sync'd 0->1.
// - Each scl rise shifts mosi into an 8-bit register; bit counter 0..7.
//   On the 8th rise the byte completes; dc is sampled on that same edge.
// - Latency: byte completes in cycle N; decode and fb write happen in N+1.
// - Reset values: fb_wr_en 0, fb_addr 0, fb_data 0, display_on 0, invert 0,
//   contrast RESET_CONTRAST, col=col_start=0, col_end=127, page=page_start=0,
//   page_end=7, mode=horizontal, bit count 0, pending args 0.
// - Reset mid-byte discards partial bits; the next scl rise is bit 7.
// - Decoder FSM: IDLE, ARG1, ARG2.
//   1-arg cmds (0x81,0x20,0xA8,0xD3,0xD5,0xD9,0xDA,0xDB,0x8D) -> ARG1 -> IDLE.
//   2-arg cmds (0x21,0x22) -> ARG1 -> ARG2 -> IDLE.
//   0x81 arg -> contrast. 0x20 arg[1:0]: 0 horiz, 1 vert, 2 page; 3 ignored.
//   0x21 arg1 -> col_start and col (masked [6:0]); arg2 -> col_end.
//   0x22 arg1 -> page_start and page (masked [2:0]); arg2 -> page_end.
//   Other 1-arg cmd args are consumed and discarded.
//   0xAE/0xAF/0xA6/0xA7 act in IDLE; all other commands are 0 arg, ignored.
// - dc=1 byte in any state: forces IDLE (drops pending args), then writes.
// - Data write: fb_wr_en=1 for one cycle, fb_addr={page,col}, fb_data=byte,
//   then pointer advances:
//   horiz: col==col_end ? (col=col_start, page advances) : col+1
//   vert : page==page_end ? (page=page_start, col advances) : page+1
//   page : col==col_end ? col=col_start : col+1; page unchanged
//   Advances: page==page_end -> page_start, else page+1 (mod 8);
//   col==col_end -> col_start, else col+1 (mod 128).
//   start>end is legal; pointer wraps mod 128 / mod 8 until it equals end.
// - fb_addr/fb_data hold their last values while fb_wr_en=0.
//
// CONFIGURATION
//   SSD1306_FRAME_DONE_EN defined: frame_done port exists; pulses 1 cycle,
//     coincident with fb_wr_en, when the write wraps both pointers
//     (col==col_end and page==page_end in horiz/vert mode; never in page
//     mode). Reset value 0.
//   Undefined: port absent; no frame logic synthesized.
//
// TESTING
//   1. Reset, send data 0xA5 -> fb_wr_en once, fb_addr=0, fb_data=8'hA5.
//   2. Cmd 0x21,0x10,0x12; 0x22,0x02,0x03; 4 data bytes -> addrs
//      {2,0x10},{2,0x11},{2,0x12},{3,0x10}.
//   3. Cmd 0x81,0x40; 0xAF; 0xA7 -> contrast=8'h40, display_on=1, invert=1.
//   4. Send 0x81 (dc=0), then data 0x33 (dc=1) -> write of 8'h33 at the
//      current pointer; contrast unchanged.
//   5. 1024 data bytes after reset (horiz, full window) -> last write at
//      addr 10'h3FF; pointer returns to 0; frame_done pulses on write 1024
//      (with SSD1306_FRAME_DONE_EN).
//   6. Assert rst after 5 bits of a byte, then send 0xC3 -> one byte 8'hC3;
//      no stray write.

Source files
------------

// File: rtl/ssd1306_spi_receiver_if.sv
// Bus bundle between the AVR core's 3-wire OLED output and the SSD1306 receiver.
// The master drives the serial pins and observes the framebuffer/status side.
// The slave is the receiver.
// The frame_done signal exists only when SSD1306_FRAME_DONE_EN is defined.
`timescale 1ns/1ps

interface ssd1306_spi_receiver_if;
  logic       spi_scl;
  logic       spi_mosi;
  logic       dc;
  logic       fb_wr_en;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       display_on;
  logic       invert;
  logic [7:0] contrast;
`ifdef SSD1306_FRAME_DONE_EN
  logic       frame_done;
`endif

  modport master (
    output spi_scl, spi_mosi, dc,
    input  fb_wr_en, fb_addr, fb_data, display_on, invert, contrast
`ifdef SSD1306_FRAME_DONE_EN
    , input frame_done
`endif
  );

  modport slave (
    input  spi_scl, spi_mosi, dc,
    output fb_wr_en, fb_addr, fb_data, display_on, invert, contrast
`ifdef SSD1306_FRAME_DONE_EN
    , output frame_done
`endif
  );
endinterface

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306-compatible OLED slave.
// It samples the asynchronous 3-wire SPI stream and assembles MSB-first bytes.
// Command bytes (dc=0) drive a small decoder FSM. Data bytes (dc=1) become
// framebuffer writes through an auto-advancing {page,col} pointer.
// There is no chip select, so byte framing starts at reset.
// Optional feature macro: SSD1306_FRAME_DONE_EN adds the frame_done output.
`timescale 1ns/1ps

module ssd1306_spi_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [7:0]  RESET_CONTRAST = 8'h7F
) (
  input logic                   clk,
  input logic                   rst,
  ssd1306_spi_receiver_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARG1    = 2'd1;
  localparam logic [1:0] ST_ARG2    = 2'd2;

  localparam logic [1:0] MODE_HORIZ = 2'd0;
  localparam logic [1:0] MODE_VERT  = 2'd1;
  localparam logic [1:0] MODE_PAGE  = 2'd2;

  // ---------------------------------------------------------------------------
  // Input synchronizers and scl edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] dc_sync_q;
  logic                   scl_prev_q;
  logic                   scl_s;
  logic                   mosi_s;
  logic                   dc_s;
  logic                   scl_rise;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s     = dc_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;

  // All three pins go through equal-length chains so mosi/dc stay aligned with scl.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <=, so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      scl_sync_q  <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      scl_prev_q  <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], bus.spi_scl};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], bus.dc};
      scl_prev_q  <= scl_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte assembly: the first rise after reset is bit 7
  // ---------------------------------------------------------------------------
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       byte_done_q;
  logic [7:0] byte_q;
  logic       byte_dc_q;

  // Shift on each scl rise; the eighth rise publishes the byte with its dc.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      byte_q      <= '0;
      byte_dc_q   <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      if (scl_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done_q <= 1'b1;
          byte_q      <= {shift_q, mosi_s};
          byte_dc_q   <= dc_s;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command decoder, status registers and write pointer
  // ---------------------------------------------------------------------------
  logic [1:0] state_q,      state_d;
  logic [7:0] cmd_q,        cmd_d;
  logic [7:0] contrast_q,   contrast_d;
  logic       display_on_q, display_on_d;
  logic       invert_q,     invert_d;
  logic [1:0] mode_q,       mode_d;
  logic [6:0] col_q,        col_d;
  logic [6:0] col_start_q,  col_start_d;
  logic [6:0] col_end_q,    col_end_d;
  logic [2:0] page_q,       page_d;
  logic [2:0] page_start_q, page_start_d;
  logic [2:0] page_end_q,   page_end_d;
  logic       fb_wr_en_q,   fb_wr_en_d;
  logic [9:0] fb_addr_q,    fb_addr_d;
  logic [7:0] fb_data_q,    fb_data_d;
`ifdef SSD1306_FRAME_DONE_EN
  logic       frame_done_q, frame_done_d;
`endif

  logic       col_wrap;
  logic       page_wrap;
  logic [6:0] col_next;
  logic [2:0] page_next;

  // Single-step advance of each pointer axis inside its window.
  // The step wraps modulo the axis size until it reaches the end value.
  assign col_wrap  = (col_q == col_end_q);
  assign page_wrap = (page_q == page_end_q);
  assign col_next  = col_wrap  ? col_start_q  : col_q + 7'd1;
  assign page_next = page_wrap ? page_start_q : page_q + 3'd1;

  function automatic logic is_one_arg(input logic [7:0] c);
    case (c)
      8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5,
      8'hD9, 8'hDA, 8'hDB, 8'h8D: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

  // Next-state decode of one completed byte.
  always_comb begin
    // NOTE: every signal written here gets its hold value first.
    // A path that skips an assignment then cannot infer a latch.
    state_d      = state_q;
    cmd_d        = cmd_q;
    contrast_d   = contrast_q;
    display_on_d = display_on_q;
    invert_d     = invert_q;
    mode_d       = mode_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    fb_wr_en_d   = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
`ifdef SSD1306_FRAME_DONE_EN
    frame_done_d = 1'b0;
`endif

    if (byte_done_q) begin
      if (byte_dc_q) begin
        // Data always wins: any pending command arguments are dropped.
        state_d    = ST_IDLE;
        fb_wr_en_d = 1'b1;
        fb_addr_d  = {page_q, col_q};
        fb_data_d  = byte_q;
        case (mode_q)
          MODE_VERT: begin
            page_d = page_next;
            if (page_wrap) col_d = col_next;
          end
          MODE_PAGE: begin
            col_d = col_next;
          end
          default: begin
            col_d = col_next;
            if (col_wrap) page_d = page_next;
          end
        endcase
`ifdef SSD1306_FRAME_DONE_EN
        frame_done_d = (mode_q != MODE_PAGE) && col_wrap && page_wrap;
`endif
      end else begin
        case (state_q)
          ST_ARG1: begin
            state_d = ST_IDLE;
            case (cmd_q)
              8'h81: contrast_d = byte_q;
              8'h20: if (byte_q[1:0] != 2'd3) mode_d = byte_q[1:0];
              8'h21: begin
                col_start_d = byte_q[6:0];
                col_d       = byte_q[6:0];
                state_d     = ST_ARG2;
              end
              8'h22: begin
                page_start_d = byte_q[2:0];
                page_d       = byte_q[2:0];
                state_d      = ST_ARG2;
              end
              default: ;
            endcase
          end
          ST_ARG2: begin
            state_d = ST_IDLE;
            if (cmd_q == 8'h21) col_end_d  = byte_q[6:0];
            if (cmd_q == 8'h22) page_end_d = byte_q[2:0];
          end
          default: begin
            case (byte_q)
              8'hAE: display_on_d = 1'b0;
              8'hAF: display_on_d = 1'b1;
              8'hA6: invert_d     = 1'b0;
              8'hA7: invert_d     = 1'b1;
              8'h21, 8'h22: begin
                cmd_d   = byte_q;
                state_d = ST_ARG1;
              end
              default: begin
                if (is_one_arg(byte_q)) begin
                  cmd_d   = byte_q;
                  state_d = ST_ARG1;
                end
              end
            endcase
          end
        endcase
      end
    end
  end

  // Register the decoder outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      contrast_q   <= RESET_CONTRAST;
      display_on_q <= 1'b0;
      invert_q     <= 1'b0;
      mode_q       <= MODE_HORIZ;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= 7'd127;
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= 3'd7;
      fb_wr_en_q   <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
`ifdef SSD1306_FRAME_DONE_EN
      frame_done_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      contrast_q   <= contrast_d;
      display_on_q <= display_on_d;
      invert_q     <= invert_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      fb_wr_en_q   <= fb_wr_en_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
`ifdef SSD1306_FRAME_DONE_EN
      frame_done_q <= frame_done_d;
`endif
    end
  end

  assign bus.fb_wr_en   = fb_wr_en_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_data    = fb_data_q;
  assign bus.display_on = display_on_q;
  assign bus.invert     = invert_q;
  assign bus.contrast   = contrast_q;
`ifdef SSD1306_FRAME_DONE_EN
  assign bus.frame_done = frame_done_q;
`endif

endmodule
